// File: rtl/cdb_arb.sv
// Common data bus arbiter: per-source result FIFOs drained round-robin onto
// N_CDB registered broadcast channels, with flush and backpressure.
module cdb_arb #(
    parameter int ROB_SIZE_CLOG = 5,
    parameter int DATA_LEN      = 32,
    parameter int N_SRC         = 4,
    parameter int N_CDB         = 2,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    flush,
    input  logic [N_SRC-1:0]                        src_v,
    input  logic [N_SRC-1:0][ROB_SIZE_CLOG-1:0]     src_robid,
    input  logic [N_SRC-1:0][DATA_LEN-1:0]          src_data,
    output logic [N_SRC-1:0]                        src_rdy,
    output logic [N_CDB-1:0]                        cdb_v,
    output logic [N_CDB-1:0][ROB_SIZE_CLOG-1:0]     cdb_robid,
    output logic [N_CDB-1:0][DATA_LEN-1:0]          cdb_data,
    output logic                                    busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SRC_W = $clog2(N_SRC);
    localparam int ENT_W = ROB_SIZE_CLOG + DATA_LEN;

    logic [N_SRC-1:0]                    nonempty;
    logic [N_SRC-1:0]                    pop;
    logic [N_SRC-1:0][ROB_SIZE_CLOG-1:0] head_robid;
    logic [N_SRC-1:0][DATA_LEN-1:0]      head_data;

    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_CDB-1:0]                    cdb_v_q;
    logic [N_CDB-1:0][ROB_SIZE_CLOG-1:0] cdb_robid_q;
    logic [N_CDB-1:0][DATA_LEN-1:0]      cdb_data_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_fifo
        logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
        logic [CNT_W-1:0] count_q, count_d;
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic             push;
        logic [ENT_W-1:0] head;

        // Ready comes only from the registered count: no same-cycle pop bypass.
        assign src_rdy[gi]    = (count_q < CNT_W'(FIFO_DEPTH));
        assign nonempty[gi]   = (count_q != '0);
        assign push           = src_v[gi] & src_rdy[gi];
        assign head           = mem_q[rd_ptr_q];
        assign head_robid[gi] = head[ENT_W-1:DATA_LEN];
        assign head_data[gi]  = head[DATA_LEN-1:0];

        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= {src_robid[gi], src_data[gi]};
            end
        end

        always_comb begin
            count_d  = count_q;
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            if (flush) begin
                count_d  = '0;
                rd_ptr_d = '0;
                wr_ptr_d = '0;
            end else begin
                if (push) begin
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                end
                if (pop[gi]) begin
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                end
                case ({push, pop[gi]})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                count_q  <= count_d;
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
            end
        end
    end

    logic [N_CDB-1:0]            grant_v;
    logic [N_CDB-1:0][SRC_W-1:0] grant_src;
    logic [SRC_W-1:0]            last_src;
    logic [SRC_W:0]              scan_sum;
    logic [SRC_W-1:0]            scan_idx;
    int                          n_grant;

    // Walk sources from rr_ptr; the n-th non-empty head lands on channel n.
    always_comb begin
        grant_v   = '0;
        grant_src = '0;
        pop       = '0;
        last_src  = rr_ptr_q;
        scan_sum  = '0;
        scan_idx  = '0;
        n_grant   = 0;
        for (int off = 0; off < N_SRC; off++) begin
            scan_sum = {1'b0, rr_ptr_q} + (SRC_W + 1)'(off);
            if (scan_sum >= (SRC_W + 1)'(N_SRC)) begin
                scan_sum = scan_sum - (SRC_W + 1)'(N_SRC);
            end
            scan_idx = scan_sum[SRC_W-1:0];
            if (nonempty[scan_idx] && (n_grant < N_CDB)) begin
                for (int k = 0; k < N_CDB; k++) begin
                    if (k == n_grant) begin
                        grant_v[k]   = 1'b1;
                        grant_src[k] = scan_idx;
                    end
                end
                pop[scan_idx] = 1'b1;
                last_src      = scan_idx;
                n_grant       = n_grant + 1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (!flush && (grant_v != '0)) begin
            if (last_src == SRC_W'(N_SRC - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = last_src + SRC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cdb_v_q     <= '0;
            cdb_robid_q <= '0;
            cdb_data_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_v_q  <= flush ? '0 : grant_v;
            for (int k = 0; k < N_CDB; k++) begin
                if (grant_v[k] && !flush) begin
                    cdb_robid_q[k] <= head_robid[grant_src[k]];
                    cdb_data_q[k]  <= head_data[grant_src[k]];
                end
            end
        end
    end

    assign cdb_v     = cdb_v_q;
    assign cdb_robid = cdb_robid_q;
    assign cdb_data  = cdb_data_q;
    assign busy      = (|nonempty) | (|cdb_v_q);

endmodule

// File: tb/tb_cdb_arb.sv
// Bench for cdb_arb: queue-per-source scoreboard with round-robin expectation,
// compared against the broadcast registers every cycle, plus directed scenarios.
module tb_cdb_arb;
    localparam int NS    = 4;
    localparam int NC    = 2;
    localparam int RW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 flush     = 1'b0;
    logic [NS-1:0]        src_v     = '0;
    logic [NS-1:0][RW-1:0] src_robid = '0;
    logic [NS-1:0][DW-1:0] src_data  = '0;
    logic [NS-1:0]        src_rdy;
    logic [NC-1:0]        cdb_v;
    logic [NC-1:0][RW-1:0] cdb_robid;
    logic [NC-1:0][DW-1:0] cdb_data;
    logic                 busy;

    cdb_arb #(
        .ROB_SIZE_CLOG(RW), .DATA_LEN(DW), .N_SRC(NS), .N_CDB(NC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src_v(src_v), .src_robid(src_robid), .src_data(src_data),
        .src_rdy(src_rdy), .cdb_v(cdb_v), .cdb_robid(cdb_robid),
        .cdb_data(cdb_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RW-1:0] robid;
        logic [DW-1:0] data;
    } ent_t;

    ent_t                  mq [NS][$];
    int                    m_rr = 0;
    bit   [NS-1:0]         m_acc = '0;
    logic [NC-1:0]         exp_v = '0;
    logic [NC-1:0][RW-1:0] exp_robid = '0;
    logic [NC-1:0][DW-1:0] exp_data = '0;
    int                    checks = 0;
    int                    fails = 0;
    int                    seqn = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance the reference by one clock edge using the inputs currently driven.
    task automatic model_step();
        ent_t e;
        int ng, last, s;
        for (int i = 0; i < NS; i++) begin
            m_acc[i] = src_v[i] && (mq[i].size() < DEPTH);
        end
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            m_rr = 0; m_acc = '0;
            exp_v = '0; exp_robid = '0; exp_data = '0;
        end else if (flush) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            m_acc = '0;
            exp_v = '0;
        end else begin
            ng = 0; last = -1;
            exp_v = '0;
            for (int off = 0; off < NS; off++) begin
                s = (m_rr + off) % NS;
                if (mq[s].size() > 0 && ng < NC) begin
                    e = mq[s].pop_front();
                    exp_v[ng] = 1'b1;
                    exp_robid[ng] = e.robid;
                    exp_data[ng] = e.data;
                    ng++;
                    last = s;
                end
            end
            if (ng > 0) m_rr = (last + 1) % NS;
            for (int i = 0; i < NS; i++) begin
                if (m_acc[i]) mq[i].push_back({src_robid[i], src_data[i]});
            end
        end
    endtask

    task automatic check_outputs();
        logic [NS-1:0] rdy_e;
        logic busy_e;
        busy_e = (exp_v != '0);
        for (int i = 0; i < NS; i++) begin
            rdy_e[i] = (mq[i].size() < DEPTH);
            if (mq[i].size() > 0) busy_e = 1'b1;
        end
        chk("cdb_v", 64'(cdb_v), 64'(exp_v));
        for (int k = 0; k < NC; k++) begin
            chk($sformatf("cdb_robid%0d", k), 64'(cdb_robid[k]), 64'(exp_robid[k]));
            chk($sformatf("cdb_data%0d", k), 64'(cdb_data[k]), 64'(exp_data[k]));
            if (cdb_v[k]) $display("t=%0t cdb ch%0d robid=%0d data=%h", $time, k, cdb_robid[k], cdb_data[k]);
        end
        chk("src_rdy", 64'(src_rdy), 64'(rdy_e));
        chk("busy", 64'(busy), 64'(busy_e));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Every source offers a result; an unaccepted offer is held unchanged.
    task automatic drive_all();
        for (int s = 0; s < NS; s++) begin
            if (!src_v[s] || m_acc[s]) begin
                src_robid[s] = RW'(s);
                src_data[s]  = {4'(s), 28'(seqn)};
                seqn++;
            end
            src_v[s] = 1'b1;
        end
    endtask

    initial begin
        int seq, nxt, rr_saved;

        // Reset
        rst_n = 1'b0;
        cycle(); cycle();
        chk("reset_rdy", 64'(src_rdy), 64'hF);
        chk("reset_v", 64'(cdb_v), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;

        // Single result from source 2
        src_v = 4'b0100; src_robid[2] = 5'd7; src_data[2] = 32'hDEADBEEF;
        cycle();
        src_v = '0;
        cycle();
        chk("single_v", 64'(cdb_v), 64'h1);
        chk("single_robid", 64'(cdb_robid[0]), 64'd7);
        chk("single_data", 64'(cdb_data[0]), 64'hDEADBEEF);
        cycle();
        chk("single_v_drop", 64'(cdb_v), 64'h0);
        chk("single_busy_drop", 64'(busy), 64'h0);

        // Random bursty traffic with held offers
        for (int c = 0; c < 40; c++) begin
            for (int s = 0; s < NS; s++) begin
                if (!src_v[s] || m_acc[s]) begin
                    src_v[s]     = 1'($urandom_range(0, 1));
                    src_robid[s] = RW'($urandom_range(0, 31));
                    src_data[s]  = {4'(s), 28'(seqn)};
                    seqn++;
                end
            end
            cycle();
        end
        src_v = '0;
        for (int c = 0; c < 4; c++) cycle();

        // Fairness from rr_ptr=0 with saturating traffic (also fills FIFOs)
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            drive_all();
            cycle();
            if (j >= 1) begin
                chk("fair_v", 64'(cdb_v), 64'h3);
                chk("fair_ch0", 64'(cdb_robid[0]), 64'(((j - 1) % 2) * 2));
                chk("fair_ch1", 64'(cdb_robid[1]), 64'(((j - 1) % 2) * 2 + 1));
            end
        end
        src_v = '0;
        for (int c = 0; c < 4; c++) cycle();

        // Wrap-around through source 3 alone
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        seq = 0; nxt = 0;
        for (int c = 0; c < 30 && (seq < 10 || nxt < 10); c++) begin
            src_v = (seq < 10) ? 4'b1000 : 4'b0000;
            src_robid[3] = RW'(seq);
            src_data[3]  = {4'd3, 28'(seq)};
            cycle();
            if (src_v[3] && m_acc[3]) seq++;
            if (cdb_v[0]) begin
                chk("wrap_order", 64'(cdb_robid[0]), 64'(nxt));
                nxt++;
            end
            chk("wrap_ch1_idle", 64'(cdb_v[1]), 64'h0);
        end
        chk("wrap_count", 64'(nxt), 64'd10);

        // Flush with all sources pushing; rr_ptr must survive
        src_v = '0;
        drive_all(); cycle();
        drive_all(); cycle();
        rr_saved = m_rr;
        flush = 1'b1;
        drive_all(); cycle();
        flush = 1'b0;
        chk("flush_v", 64'(cdb_v), 64'h0);
        chk("flush_rdy", 64'(src_rdy), 64'hF);
        chk("flush_busy", 64'(busy), 64'h0);
        src_v = '0;
        cycle(); cycle();
        drive_all(); cycle();
        src_v = '0;
        cycle();
        chk("flush_rr_ch0", 64'(cdb_robid[0]), 64'(rr_saved));
        chk("flush_rr_ch1", 64'(cdb_robid[1]), 64'((rr_saved + 1) % NS));
        for (int c = 0; c < 3; c++) cycle();

        // Reset in the middle of full traffic
        for (int c = 0; c < 5; c++) begin drive_all(); cycle(); end
        rst_n = 1'b0;
        drive_all(); cycle();
        rst_n = 1'b1;
        chk("rst_v", 64'(cdb_v), 64'h0);
        chk("rst_robid", 64'(cdb_robid), 64'h0);
        chk("rst_data", 64'(cdb_data), 64'h0);
        chk("rst_rdy", 64'(src_rdy), 64'hF);
        chk("rst_busy", 64'(busy), 64'h0);
        drive_all(); cycle();
        drive_all(); cycle();
        chk("rst_order_v", 64'(cdb_v), 64'h3);
        chk("rst_order_ch0", 64'(cdb_robid[0]), 64'd0);
        chk("rst_order_ch1", 64'(cdb_robid[1]), 64'd1);
        src_v = '0;
        for (int c = 0; c < 6; c++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/cdb_arb.md
# cdb_arb

Multi-source common data bus (CDB) arbiter with per-source result buffering. It sits between the functional-unit result outputs and the ROB/reservation-station wakeup logic. Each of N_SRC execution units pushes completed results into a private FIFO. Each cycle a round-robin arbiter drains up to N_CDB FIFO heads onto N_CDB registered broadcast channels. The block supersedes the single-channel pipeline register with backpressure, buffering, fair arbitration and flush.

## Interface
- ROB_SIZE_CLOG, 5, ROB id width
- DATA_LEN, 32, result data width
- N_SRC, 4, number of result sources (>=2)
- N_CDB, 2, number of broadcast channels (1..N_SRC)
- FIFO_DEPTH, 2, entries per source FIFO (>=1)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  pipeline flush (mispredict/exception); discards all buffered and in-flight results
- src_v  in  N_SRC  per-source result valid
- src_robid  in  N_SRC x ROB_SIZE_CLOG  per-source ROB id
- src_data  in  N_SRC x DATA_LEN  per-source result
- src_rdy  out  N_SRC  per-source FIFO can accept (not full)
- cdb_v  out  N_CDB  broadcast valid per channel
- cdb_robid  out  N_CDB x ROB_SIZE_CLOG  broadcast ROB id
- cdb_data  out  N_CDB x DATA_LEN  broadcast data
- busy  out  1  any FIFO non-empty or any cdb_v set

## Operation
- Push: source i writes when src_v[i] && src_rdy[i]. A result with src_v[i]=1 and src_rdy[i]=0 is not accepted; the source holds it.
- src_rdy[i] = (count[i] < FIFO_DEPTH), computed from registered count. A same-cycle pop does not raise src_rdy, so there is no full-bypass.
- Each FIFO is circular with rd/wr pointers that wrap modulo FIFO_DEPTH, plus a count of width $clog2(FIFO_DEPTH+1).
- Arbitration is combinational over non-empty FIFO heads:
  - Scan sources in order rr_ptr, rr_ptr+1, … (mod N_SRC).
  - The first non-empty source goes to channel 0, the next to channel 1, up to N_CDB grants.
  - Each source is popped at most once per cycle.
- rr_ptr update: if at least one grant, rr_ptr <= (index of last granted source + 1) mod N_SRC. Otherwise rr_ptr is unchanged.
- Output registers:
  - Granted channel k: cdb_v[k]<=1 and cdb_robid[k]/cdb_data[k] load the granted head.
  - Ungranted channel: cdb_v[k]<=0; robid/data hold their previous value.
  - Channels are filled contiguously from 0. If cdb_v[k]=1 then cdb_v[j]=1 for all j<k.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
- Flush (rst_n=1, flush=1):
  - Next cycle: all counts and pointers are 0 and cdb_v is all 0.
  - Pushes and pops in the flush cycle are discarded.
  - rr_ptr is retained.
- Reset (rst_n=0): counts, pointers, rr_ptr, cdb_v, cdb_robid and cdb_data all go to 0. Reset has priority over flush. Reset mid-operation drops all buffered results.
- No data transformation; robid and data pass bit-exact.

## Timing
- Latency from accepted push (cycle t) to broadcast: cdb_v visible in cycle t+2 if that source wins arbitration in cycle t+1.
  - t edge: FIFO write.
  - t+1: arbitration.
  - t+1 edge: output register.
- Throughput: up to N_CDB results per cycle aggregate, 1 per source per cycle.
- Starvation bound: a non-empty source is granted within ceil(N_SRC/N_CDB) cycles.
- Reset values: src_rdy all 1 once rst_n is sampled low (count=0). cdb_v=0, cdb_robid=0, cdb_data=0, busy=0.
- cdb_* are direct register outputs with no combinational input-to-output path. src_rdy depends only on registers.

## Test plan
- Single result: reset, then src_v[2]=1, robid=5'd7, data=32'hDEADBEEF for 1 cycle -> exactly one cycle of cdb_v=2'b01, cdb_robid[0]=7, cdb_data[0]=DEADBEEF, 2 cycles after the push; busy drops the cycle after.
- Fairness: all 4 sources push continuously with robid = source id; rr_ptr=0 -> grants alternate {0,1},{2,3},{0,1}…; no source waits more than 2 cycles.
- Backpressure: hold src_v[0]=1 with N_CDB-saturating traffic on sources 1-3 so FIFO 0 fills -> src_rdy[0]=0 after 2 accepted entries; no entry is lost or duplicated (scoreboard by robid); FIFO order is preserved per source.
- Wrap-around: stream 10 results through source 3 alone, robid 0..9 -> broadcast in order 0..9 on channel 0, one per cycle after fill, with FIFO pointers wrapping; cdb_v[1] never set.
- Flush: fill all FIFOs and assert flush for 1 cycle while src_v=all 1 -> next cycle cdb_v=0, src_rdy=all 1, busy=0; no flushed robid ever appears on the CDB; rr_ptr is unchanged.
- Reset mid-stream: rst_n=0 for 1 cycle during full traffic -> next cycle all outputs 0 and the rr_ptr=0 grant order restarts at source 0.
